// File: rtl/uart_tx_8n1_pkg.sv
// Shared definitions for the serial link: FSM state encodings and line levels.
// The matching receiver imports the same package.
package uart_tx_8n1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_8n1_if.sv
// Valid/ready word handshake between the core-side producer and the transmitter.
interface uart_tx_8n1_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: bit_tick marks the last clk of each CLKS_PER_BIT period.
// Shared with the receiver.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic bit_tick
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign bit_tick = en && (r_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= bit_tick ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_8n1.sv
// 8N1-style serial transmitter: accepts a word on the handshake, sends start, data LSB-first, stop.
// tx and tx_ready are registered from next-state values so nothing combinational reaches the pins.
module uart_tx_8n1
    import uart_tx_8n1_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_8n1_if.slave    s_if,
    output logic            busy,
    output logic            tx
);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    uart_state_e          r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [BIT_W-1:0]     r_bit_idx, w_bit_idx_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 r_tx_ready, w_tx_ready_nxt;
    logic                 w_bit_tick;
    logic                 w_in_idle;

    assign w_in_idle     = (r_state == ST_IDLE);
    assign s_if.tx_ready = r_tx_ready;
    assign busy          = ~r_tx_ready;
    assign tx            = r_tx;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .en       (~w_in_idle),
        .clear    (w_in_idle),
        .bit_tick (w_bit_tick)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_tx_nxt      = LINE_IDLE;

        unique case (r_state)
            ST_IDLE: begin
                if (s_if.tx_valid && r_tx_ready) begin
                    w_state_nxt   = ST_START;
                    w_shift_nxt   = s_if.tx_data;
                    w_bit_idx_nxt = '0;
                end
            end
            ST_START: begin
                if (w_bit_tick) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_tick) begin
                    if (r_bit_idx == LAST_DATA) begin
                        w_state_nxt   = ST_STOP;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                        w_shift_nxt   = r_shift >> 1;
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_tick) begin
                    if (r_bit_idx == LAST_STOP) begin
                        w_state_nxt   = ST_IDLE;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Line level follows the state being entered, so tx changes on the same edge as the FSM.
        unique case (w_state_nxt)
            ST_START: w_tx_nxt = START_LVL;
            ST_DATA:  w_tx_nxt = w_shift_nxt[0];
            ST_STOP:  w_tx_nxt = STOP_LVL;
            default:  w_tx_nxt = LINE_IDLE;
        endcase

        w_tx_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    // NOTE: the shift register is plain datapath flops, so it takes the async reset like the rest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_tx       <= LINE_IDLE;
            r_tx_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_tx       <= w_tx_nxt;
            r_tx_ready <= w_tx_ready_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_8n1.sv
// Directed bench for uart_tx_8n1: table of single frames plus back-to-back, drop, reset and 2-stop cases.
module tb_uart_tx_8n1;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;   // serial bit k (start first) lives at index k
    } vec_t;

    logic clk;
    logic reset;
    logic busy_a, tx_a;
    logic busy_b, tx_b;

    int total = 0;
    int bad   = 0;

    uart_tx_8n1_if #(.DATA_BITS(8)) if_a ();
    uart_tx_8n1_if #(.DATA_BITS(8)) if_b ();

    uart_tx_8n1 #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .s_if  (if_a),
        .busy  (busy_a),
        .tx    (tx_a)
    );

    uart_tx_8n1 #(.CLKS_PER_BIT(3), .DATA_BITS(8), .STOP_BITS(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .s_if  (if_b),
        .busy  (busy_b),
        .tx    (tx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_tx(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction

    function automatic logic get_ready(input bit sel);
        return sel ? if_b.tx_ready : if_a.tx_ready;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    task automatic drive(input bit sel, input logic [7:0] data, input logic valid);
        if (sel) begin
            if_b.tx_data  = data;
            if_b.tx_valid = valid;
        end else begin
            if_a.tx_data  = data;
            if_a.tx_valid = valid;
        end
    endtask

    // Called at a negedge: present a word and let the next rising edge accept it.
    task automatic start_tx(input bit sel, input logic [7:0] data);
        check($sformatf("ready_before_%0h", data), get_ready(sel), 1'b1);
        drive(sel, data, 1'b1);
        @(posedge clk);
    endtask

    // Checks every clk of a frame right after acceptance, then the idle cycle that follows.
    task automatic run_frame(input bit sel, input logic [10:0] exp, input int nbits, input int cpb,
                             input logic [7:0] first_data, input logic first_valid,
                             input int pulse_cyc, input logic [7:0] pulse_data);
        int ready_errs = 0;
        for (int c = 1; c <= nbits * cpb; c++) begin
            @(negedge clk);
            if (c == 1) drive(sel, first_data, first_valid);
            if (c == pulse_cyc) drive(sel, pulse_data, 1'b1);
            if (pulse_cyc > 0 && c == pulse_cyc + 1) drive(sel, pulse_data, 1'b0);
            check($sformatf("tx_%0s_c%0d", sel ? "b" : "a", c), get_tx(sel), exp[(c - 1) / cpb]);
            if (get_ready(sel) !== 1'b0 || get_busy(sel) !== 1'b1) ready_errs++;
        end
        check($sformatf("ready_low_%0s", sel ? "b" : "a"), ready_errs, 0);
        @(negedge clk);
        check("ready_after_frame", get_ready(sel), 1'b1);
        check("busy_after_frame", get_busy(sel), 1'b0);
        check("tx_after_frame", get_tx(sel), 1'b1);
    endtask

    initial begin
        vec_t vecs [4];
        int   quiet_errs;

        vecs[0] = '{data: 8'hA5, frame: 11'b00_1101001010};
        vecs[1] = '{data: 8'h01, frame: 11'b00_1000000010};
        vecs[2] = '{data: 8'h80, frame: 11'b00_1100000000};
        vecs[3] = '{data: 8'h5A, frame: 11'b00_1010110100};

        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b0);

        // Reset state and quiet idle line
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_tx_a", tx_a, 1'b1);
        check("rst_ready_a", if_a.tx_ready, 1'b1);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_tx_b", tx_b, 1'b1);
        check("rst_ready_b", if_b.tx_ready, 1'b1);
        quiet_errs = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || if_a.tx_ready !== 1'b1 || busy_a !== 1'b0) quiet_errs++;
        end
        check("idle_quiet", quiet_errs, 0);

        // Single frames from the table
        for (int i = 0; i < 4; i++) begin
            start_tx(1'b0, vecs[i].data);
            run_frame(1'b0, vecs[i].frame, 10, 4, vecs[i].data, 1'b0, -1, 8'h00);
            repeat (2) @(negedge clk);
        end

        // Back-to-back with tx_valid held: 00 then FF, one extra idle clk between frames
        start_tx(1'b0, 8'h00);
        run_frame(1'b0, 11'b00_1000000000, 10, 4, 8'hFF, 1'b1, -1, 8'h00);
        start_tx(1'b0, 8'hFF);
        run_frame(1'b0, 11'b00_1111111110, 10, 4, 8'hFF, 1'b0, -1, 8'h00);

        // tx_data change and tx_valid pulse mid-frame: A5 unchanged, 3C dropped
        repeat (2) @(negedge clk);
        start_tx(1'b0, 8'hA5);
        run_frame(1'b0, 11'b00_1101001010, 10, 4, 8'h3C, 1'b0, 10, 8'h3C);
        quiet_errs = 0;
        repeat (44) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) quiet_errs++;
        end
        check("dropped_word_quiet", quiet_errs, 0);

        // Async reset during data bit 3 of A5, then a clean 5A frame
        start_tx(1'b0, 8'hA5);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) drive(1'b0, 8'hA5, 1'b0);
        end
        check("pre_reset_tx_low", tx_a, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_tx", tx_a, 1'b1);
        check("async_reset_ready", if_a.tx_ready, 1'b1);
        check("async_reset_busy", busy_a, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_tx", tx_a, 1'b1);
        check("post_reset_ready", if_a.tx_ready, 1'b1);
        start_tx(1'b0, 8'h5A);
        run_frame(1'b0, 11'b00_1010110100, 10, 4, 8'h5A, 1'b0, -1, 8'h00);

        // Two stop bits, three clks per bit: 33-clk frame with 6 high stop clks
        start_tx(1'b1, 8'h81);
        run_frame(1'b1, 11'b11100000010, 11, 3, 8'h81, 1'b0, -1, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
